// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Also intended for use by the matching transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Resets to 1 so that an idle-high serial line produces no false start after reset.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_reg <= 1'b1;
      q        <= 1'b1;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: start-bit validation at mid-bit, LSB-first data capture,
// stop-bit check, and a one-entry valid/ready holding register with sticky error flags.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 clr_err,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_reg, state_next;
  logic [S_W-1:0]       s_cnt_reg, s_cnt_next;
  logic [N_W-1:0]       n_cnt_reg, n_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 stop_done;
  logic                 load_good;
  logic                 load_bad;
  logic                 consume;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_comb begin
    state_next = state_reg;
    s_cnt_next = s_cnt_reg;
    n_cnt_next = n_cnt_reg;
    shift_next = shift_reg;
    stop_done  = 1'b0;
    case (state_reg)
      // Start detection is not tick-gated, so any tick in this cycle is not counted.
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_reg == S_HALF) begin
            s_cnt_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_reg == S_LAST) begin
            s_cnt_next = '0;
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (n_cnt_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt_reg + 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_reg == S_LAST) begin
            s_cnt_next = '0;
            state_next = IDLE;
            stop_done  = 1'b1;
          end else begin
            s_cnt_next = s_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_good = stop_done & rx_s;
  assign load_bad  = stop_done & ~rx_s;
  assign consume   = rx_valid & rx_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      s_cnt_reg   <= '0;
      n_cnt_reg   <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_cnt_reg <= s_cnt_next;
      n_cnt_reg <= n_cnt_next;
      shift_reg <= shift_next;

      // A load coinciding with a consume replaces the byte instead of overrunning.
      if (load_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (consume) begin
        rx_valid <= 1'b0;
      end

      if (load_bad) begin
        frame_error <= 1'b1;
      end else if (clr_err) begin
        frame_error <= 1'b0;
      end

      if (load_good && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: table-driven frames plus hand-written corner sequences,
// with a scoreboard queue matching every presented byte against the bytes sent.
module tb_uart_rx_oversampled;

  localparam int OS = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;

  int tick_div = 1;
  int div_cnt  = 0;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[3];

  uart_rx_oversampled dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick        (tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .clr_err     (clr_err),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) div_cnt <= (div_cnt >= tick_div - 1) ? 0 : div_cnt + 1;
  assign tick = (tick_div <= 1) || (div_cnt == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (OS * tick_div) @(posedge clock);
      #1;
    end
    rx = 1'b1;
    $display("frame 0x%02h stop=%0d sent", data, stop_bit);
  endtask

  task automatic consume_byte();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  // A byte is presented when rx_valid rises or the held byte is replaced while valid.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clock) begin
    if (rx_valid && (!prev_valid || rx_data != prev_data)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL scoreboard_unexpected: got 0x%02h, required no byte", rx_data);
      end else begin
        check("scoreboard", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    wait_clk(4);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].stop_bit) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      wait_clk(20);
      check("vec_rx_data", rx_data, vecs[i].exp_data);
      check("vec_rx_valid", rx_valid, vecs[i].exp_valid);
      check("vec_frame_error", frame_error, vecs[i].exp_fe);
      check("vec_overrun", overrun, vecs[i].exp_ov);
      consume_byte();
      check("vec_consumed_valid", rx_valid, 0);
      check("vec_consumed_data", rx_data, vecs[i].exp_data);
      clr_err = 1'b1;
      wait_clk(1);
      clr_err = 1'b0;
      check("vec_cleared_fe", frame_error, 0);
    end

    // Short low pulse: rejected at the mid-start sample.
    @(posedge clock);
    #1;
    rx = 1'b0;
    wait_clk(5);
    rx = 1'b1;
    wait_clk(40);
    $display("glitch of 5 clocks applied");
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_frame_error", frame_error, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clk(20);
    check("after_glitch_data", rx_data, 8'h3C);
    check("after_glitch_valid", rx_valid, 1);
    check("after_glitch_fe", frame_error, 0);
    consume_byte();

    // Overrun: second byte dropped while first is held.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(20);
    check("overrun_data", rx_data, 8'h11);
    check("overrun_valid", rx_valid, 1);
    check("overrun_flag", overrun, 1);
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    check("overrun_cleared", overrun, 0);
    check("overrun_still_valid", rx_valid, 1);

    // Consume on exactly the load clock: new byte wins, no overrun.
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clock);
        #1;
        wait_clk(154);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
      end
    join
    wait_clk(20);
    check("loadwin_data", rx_data, 8'h22);
    check("loadwin_valid", rx_valid, 1);
    check("loadwin_overrun", overrun, 0);
    consume_byte();

    // Reset pulse during data bit 3 of 0xFF: partial byte must never appear.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clock);
        #1;
        wait_clk(70);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
      end
    join
    wait_clk(20);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_frame_error", frame_error, 0);
    check("midreset_overrun", overrun, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_clk(20);
    check("after_reset_data", rx_data, 8'h5A);
    check("after_reset_valid", rx_valid, 1);
    consume_byte();

    // Slow tick, back-to-back frames, consumer always ready.
    tick_div = 163;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    wait_clk(20);
    check("slow_frame_error", frame_error, 0);
    check("slow_overrun", overrun, 0);
    check("slow_valid_drained", rx_valid, 0);
    check("slow_last_data", rx_data, 8'h55);
    rx_ready = 1'b0;
    tick_div = 1;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
